mem_arbiter: RTL

- Shares one single-port synchronous RAM between the CPU instruction-fetch port and the data port. It replaces the split inst/data RAM arrangement on an inverted clock.
- Arbitrates between the two ports, issues one RAM access at a time, and waits a parametrised read latency.
- Returns read data with a one-cycle ack pulse to the winning port.
- Sits between the mips core and the unified RAM in the top level, on the same clock edge as the core.

---
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// ============================================================================
// Module   : mem_arbiter_if
// Brief    : CPU fetch/data ports and unified RAM port seen by mem_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();

    // Instruction-fetch port
    logic                  inst_req;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_ack;
    logic [DATA_W-1:0]     inst_rdata;

    // Data port
    logic                  data_req;
    logic [DATA_W/8-1:0]   data_we;
    logic [ADDR_W-1:0]     data_addr;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_ack;
    logic [DATA_W-1:0]     data_rdata;

    // Unified single-port RAM
    logic                  mem_en;
    logic [DATA_W/8-1:0]   mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    // Arbiter side
    modport slave (
        input  inst_req, inst_addr,
        output inst_ack, inst_rdata,
        input  data_req, data_we, data_addr, data_wdata,
        output data_ack, data_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // Core + RAM side
    modport master (
        output inst_req, inst_addr,
        input  inst_ack, inst_rdata,
        output data_req, data_we, data_addr, data_wdata,
        input  data_ack, data_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one single-port synchronous RAM between fetch and data ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LATENCY  = 1,
    parameter int ARB_MODE = 0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    mem_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int          c_CNT_W   = 3;
    localparam logic        c_GNT_INST = 1'b0;
    localparam logic        c_GNT_DATA = 1'b1;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_grant;
    logic                   r_last_grant;
    logic                   r_is_read;

    logic                   r_mem_en;
    logic [DATA_W/8-1:0]    r_mem_we;
    logic [ADDR_W-1:0]      r_mem_addr;
    logic [DATA_W-1:0]      r_mem_wdata;
    logic                   r_inst_ack;
    logic                   r_data_ack;
    logic [DATA_W-1:0]      r_inst_rdata;
    logic [DATA_W-1:0]      r_data_rdata;

    logic                   w_any_req;
    logic                   w_pick_data;
    logic                   w_issue;
    logic                   w_finish;

    // Data wins unless round-robin is on and data was the last port served.
    always_comb begin
        w_any_req   = bus.inst_req | bus.data_req;
        w_pick_data = bus.data_req &&
                      (!bus.inst_req || (ARB_MODE == 0) || (r_last_grant == c_GNT_INST));
        w_issue     = (r_state == S_IDLE) && w_any_req;
        w_finish    = (r_state == S_WAIT) && (r_cnt == c_CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_issue)  w_state_nxt = S_WAIT;
            S_WAIT:  if (w_finish) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt        <= '0;
            r_grant      <= c_GNT_INST;
            r_last_grant <= c_GNT_INST;
            r_is_read    <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_inst_ack   <= 1'b0;
            r_data_ack   <= 1'b0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            r_mem_en   <= w_issue;
            r_inst_ack <= 1'b0;
            r_data_ack <= 1'b0;

            if (w_issue) begin
                r_grant      <= w_pick_data;
                r_last_grant <= w_pick_data;
                r_cnt        <= c_CNT_W'(LATENCY);
                if (w_pick_data) begin
                    r_mem_we    <= bus.data_we;
                    r_mem_addr  <= bus.data_addr;
                    r_mem_wdata <= bus.data_wdata;
                    r_is_read   <= (bus.data_we == '0);
                end else begin
                    r_mem_we    <= '0;
                    r_mem_addr  <= bus.inst_addr;
                    r_mem_wdata <= '0;
                    r_is_read   <= 1'b1;
                end
            end

            if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - c_CNT_W'(1);
            end

            // Writes complete with an ack but leave the rdata registers alone.
            if (w_finish) begin
                if (r_grant == c_GNT_DATA) begin
                    r_data_ack <= 1'b1;
                    if (r_is_read) r_data_rdata <= bus.mem_rdata;
                end else begin
                    r_inst_ack   <= 1'b1;
                    r_inst_rdata <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_en     = r_mem_en;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.inst_ack   = r_inst_ack;
    assign bus.data_ack   = r_data_ack;
    assign bus.inst_rdata = r_inst_rdata;
    assign bus.data_rdata = r_data_rdata;

endmodule

`default_nettype wire
